regs_sb: RTL and testbench
==========================

// Module: regs_sb
// PURPOSE
//  Parametrised successor of the DLX register file: NREAD synchronous read ports, one write-back port,
//  plus a per-register pending-write scoreboard for decode-stage hazard stalls.
//  Sits between decode (reads Rs*, reserves destination) and write-back (WB/Rd/reg_s).
//  Register 0 is hard-wired to zero, is never written and is never busy.
// PARAMETERS
//  WIDTH   32  data width of each register
//  NREGS   32  number of architectural registers (power of 2, >=2); AW = $clog2(NREGS) (localparam)
//  NREAD   2   number of read ports
//  PEND_W  2   width of per-register pending-write counter (max 2**PEND_W-1 in flight per register)
// PORTS
//  clk         in   1              clock; all state updates on posedge
//  reset       in   1              synchronous, active-high reset
//  WB          in   1              write-back enable
//  Rd          in   AW             write-back register number
//  reg_s       in   WIDTH          write-back data
//  Rs          in   NREAD x AW     read register numbers, one per port
//  S           out  NREAD x WIDTH  read data, registered
//  Reserve     in   1              decode reserves destination Rr (instruction issued)
//  Rr          in   AW             register being reserved
//  reserve_ok  out  1              comb: 1 if a Reserve this cycle will be accepted
//  Busy        out  NREAD          comb: 1 if Rs[i] has a pending write
//  sb_err      out  1              sticky: write-back to a register with no pending reservation
// BEHAVIOUR
//  - Reset (reset=1 at posedge): all registers <= 0, all S[i] <= 0, all counters <= 0, sb_err <= 0.
//    Reset wins over every same-cycle WB/Reserve.
//  - Read: S[i] <= regs[Rs[i]] at posedge. Latency 1 cycle. S[i] is 0 whenever Rs[i]==0.
//  - Write: if WB && Rd!=0, regs[Rd] <= reg_s at posedge. WB with Rd==0 is ignored entirely;
//    no counter change, no error.
//  - Scoreboard: cnt[r] is PEND_W bits.
//    Set inc  = Reserve && reserve_ok && Rr!=0.
//    Set dec  = WB && Rd!=0 && cnt[Rd]!=0.
//    inc only: cnt[Rr]++.  dec only: cnt[Rd]--.
//    inc and dec on the same register: cnt unchanged.  On different registers: both apply.
//  - reserve_ok = (Rr==0) || (cnt[Rr] != max) || (WB && Rd==Rr).
//    A same-cycle write-back frees a slot. Reserve with reserve_ok=0 is dropped; decode must stall.
//  - Underflow: WB && Rd!=0 && cnt[Rd]==0 sets sb_err <= 1 (held until reset). The write still
//    occurs and the counter stays 0.
//  - Busy[i] = (Rs[i]!=0) && (cnt[Rs[i]]!=0), evaluated on pre-edge state (see BYPASS_EN).
//  - Multiple ports may read the same register; all of them see identical data.
// CONFIGURATION
//  REGS_SB_BYPASS_EN defined:
//   - Write-first: if WB && Rd!=0 && Rd==Rs[i], then S[i] <= reg_s.
//   - Busy[i] is forced to 0 when cnt[Rs[i]]==1 && WB && Rd==Rs[i] (value forwarded this cycle).
//  REGS_SB_BYPASS_EN undefined:
//   - Read-first: S[i] gets the old regs value. Busy[i] follows the rule above unmodified.
// STRUCTURE
//  - Package regs_sb_pkg: default WIDTH/NREGS/NREAD/PEND_W constants, typedef reg_idx_t
//    (logic [AW-1:0]), typedef word_t (logic [WIDTH-1:0]).
//  - Sub-module regs_scoreboard: counters, reserve_ok, Busy, sb_err.
//  - Top level: storage array and read ports.
//  - Storage is a flop array with synchronous read; no RAM macro inference is required.
// TESTING
//  1. Reset, then read all regs on both ports -> S=0 everywhere; Busy=0; reserve_ok=1; sb_err=0.
//  2. WB=1 Rd=5 reg_s=0xDEADBEEF; next cycle Rs[0]=5 -> S[0]=0xDEADBEEF one cycle later.
//     WB=1 Rd=0 reg_s=0x1 -> reading R0 returns 0.
//  3. Same-cycle WB Rd=7 reg_s=0x12345678 with Rs[1]=7 ->
//     S[1]=0x12345678 with REGS_SB_BYPASS_EN; old value (0) without it.
//  4. Reserve Rr=3 three times (PEND_W=2) -> Busy=1 for Rs=3; 4th Reserve sees reserve_ok=0.
//     4th Reserve together with WB Rd=3 -> reserve_ok=1 and cnt stays 3.
//  5. WB Rd=9 with cnt[9]=0 -> sb_err=1 next cycle and held; regs[9] still updated; reset clears sb_err.
//  6. Assert reset mid-traffic (pending cnt[3]=2, WB to 4 in the same cycle) ->
//     all regs 0, Busy=0, S=0 after the edge; the WB to 4 is discarded.

Source files
------------

// File: rtl/regs_sb_pkg.sv
// Shared constants and types for the regs_sb register file slice.
// Defaults match the classic 32 x 32-bit, dual-read DLX configuration.
package regs_sb_pkg;

    localparam int WIDTH_D  = 32;
    localparam int NREGS_D  = 32;
    localparam int NREAD_D  = 2;
    localparam int PEND_W_D = 2;
    localparam int AW_D     = $clog2(NREGS_D);

    typedef logic [AW_D-1:0]    reg_idx_t;
    typedef logic [WIDTH_D-1:0] word_t;

endpackage

// File: rtl/regs_scoreboard.sv
// Pending-write scoreboard: per-register in-flight counters, reserve_ok, Busy, sb_err.
// Optional macro REGS_SB_BYPASS_EN hides Busy when the last pending write forwards now.
module regs_scoreboard
    import regs_sb_pkg::*;
#(
    parameter int NREGS  = NREGS_D,
    parameter int NREAD  = NREAD_D,
    parameter int PEND_W = PEND_W_D,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      WB,
    input  logic [AW-1:0]             Rd,
    input  logic [NREAD-1:0][AW-1:0]  Rs,
    input  logic                      Reserve,
    input  logic [AW-1:0]             Rr,
    output logic                      reserve_ok,
    output logic [NREAD-1:0]          Busy,
    output logic                      sb_err
);

    localparam logic [PEND_W-1:0] CMAX = '1;
    localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);

    logic [PEND_W-1:0] cnt [NREGS];
    logic              wb_hit;
    logic              inc;
    logic              dec;
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;

    assign wb_hit     = WB && (Rd != '0);
    assign reserve_ok = (Rr == '0) || (cnt[Rr] != CMAX) || (WB && (Rd == Rr));
    assign inc        = Reserve && reserve_ok && (Rr != '0);
    assign dec        = wb_hit && (cnt[Rd] != '0);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (inc) inc_v[Rr] = 1'b1;
        if (dec) dec_v[Rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                unique case (1'b1)
                    inc_v[r] && !dec_v[r]: cnt[r] <= cnt[r] + ONE;
                    dec_v[r] && !inc_v[r]: cnt[r] <= cnt[r] - ONE;
                    default: ;
                endcase
            end
            // Write-back with nothing outstanding is a decode bug; latch it.
            if (wb_hit && (cnt[Rd] == '0)) sb_err <= 1'b1;
        end
    end

    always_comb begin
        Busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            Busy[i] = (Rs[i] != '0) && (cnt[Rs[i]] != '0);
`ifdef REGS_SB_BYPASS_EN
            if ((cnt[Rs[i]] == ONE) && WB && (Rd == Rs[i])) Busy[i] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/regs_sb.sv
// Register file with NREAD registered read ports, one write port and a hazard scoreboard.
// Optional macro REGS_SB_BYPASS_EN selects write-first reads instead of read-first.
module regs_sb
    import regs_sb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_D,
    parameter int NREGS  = NREGS_D,
    parameter int NREAD  = NREAD_D,
    parameter int PEND_W = PEND_W_D,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        WB,
    input  logic [AW-1:0]               Rd,
    input  logic [WIDTH-1:0]            reg_s,
    input  logic [NREAD-1:0][AW-1:0]    Rs,
    output logic [NREAD-1:0][WIDTH-1:0] S,
    input  logic                        Reserve,
    input  logic [AW-1:0]               Rr,
    output logic                        reserve_ok,
    output logic [NREAD-1:0]            Busy,
    output logic                        sb_err
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wb_hit;

    assign wb_hit = WB && (Rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            S <= '0;
        end else begin
            if (wb_hit) regs[Rd] <= reg_s;
            for (int i = 0; i < NREAD; i++) begin
                S[i] <= (Rs[i] == '0) ? '0 : regs[Rs[i]];
`ifdef REGS_SB_BYPASS_EN
                if (wb_hit && (Rd == Rs[i])) S[i] <= reg_s;
`endif
            end
        end
    end

    regs_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .PEND_W (PEND_W),
        .AW     (AW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .WB         (WB),
        .Rd         (Rd),
        .Rs         (Rs),
        .Reserve    (Reserve),
        .Rr         (Rr),
        .reserve_ok (reserve_ok),
        .Busy       (Busy),
        .sb_err     (sb_err)
    );

endmodule

// File: tb/tb_regs_sb.sv
// Self-checking bench for regs_sb: directed scenarios plus randomized traffic
// compared against an array/counter reference model of the register file.
module tb_regs_sb;

    localparam int NR  = 32;
    localparam int CMX = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  WB;
    logic [4:0]            Rd;
    logic [31:0]           reg_s;
    logic [1:0][4:0]       Rs;
    logic [1:0][31:0]      S;
    logic                  Reserve;
    logic [4:0]            Rr;
    logic                  reserve_ok;
    logic [1:0]            Busy;
    logic                  sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [NR];
    int          m_cnt  [NR];
    bit          m_err;
    logic [31:0] m_S    [2];

    regs_sb dut (
        .clk        (clk),
        .reset      (reset),
        .WB         (WB),
        .Rd         (Rd),
        .reg_s      (reg_s),
        .Rs         (Rs),
        .S          (S),
        .Reserve    (Reserve),
        .Rr         (Rr),
        .reserve_ok (reserve_ok),
        .Busy       (Busy),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

`ifdef REGS_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic bit exp_ok();
        return (Rr == 0) || (m_cnt[Rr] != CMX) || (WB && Rd == Rr);
    endfunction

    function automatic bit exp_busy(int i);
        bit b;
        b = (Rs[i] != 0) && (m_cnt[Rs[i]] != 0);
        if (BYP && m_cnt[Rs[i]] == 1 && WB && Rd == Rs[i]) b = 1'b0;
        return b;
    endfunction

    task automatic idle();
        reset = 0; WB = 0; Rd = 0; reg_s = 0;
        Rs = '0; Reserve = 0; Rr = 0;
    endtask

    // Advance one clock, updating the reference model from the driven inputs.
    task automatic step();
        bit ok;
        bit wbv;
        bit inc;
        bit dec;
        ok  = exp_ok();
        wbv = WB && Rd != 0;
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = 0;
                m_cnt[r]  = 0;
            end
            m_err = 0;
            m_S[0] = 0;
            m_S[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_S[i] = (Rs[i] == 0) ? 32'h0 : m_regs[Rs[i]];
                if (BYP && wbv && Rd == Rs[i]) m_S[i] = reg_s;
            end
            inc = Reserve && ok && Rr != 0;
            dec = wbv && m_cnt[Rd] != 0;
            if (wbv && m_cnt[Rd] == 0) m_err = 1;
            if (inc) m_cnt[Rr] = m_cnt[Rr] + 1;
            if (dec) m_cnt[Rd] = m_cnt[Rd] - 1;
            if (wbv) m_regs[Rd] = reg_s;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (sb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_sb_err got %b want 0", sb_err);
        end
        for (int r = 0; r < NR; r++) begin
            Rs[0] = 5'(r);
            Rs[1] = 5'(NR - 1 - r);
            Rr = 5'(r);
            #1;
            n_tests++;
            if (Busy !== 2'b00 || reserve_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_busy_ok r=%0d got busy=%b ok=%b want 00 1",
                         r, Busy, reserve_ok);
            end
            step();
            n_tests++;
            if (S[0] !== 32'h0 || S[1] !== 32'h0) begin
                n_fail++; $display("FAIL reset_read r=%0d got %h %h want 0 0", r, S[0], S[1]);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        do_reset();
        WB = 1; Rd = 5; reg_s = 32'hDEADBEEF;
        step();
        idle();
        Rs[0] = 5;
        Rs[1] = 5;
        step();
        n_tests++;
        if (S[0] !== 32'hDEADBEEF || S[1] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_read got %h %h want deadbeef", S[0], S[1]);
        end
        idle();
        WB = 1; Rd = 0; reg_s = 32'h1;
        step();
        idle();
        Rs[0] = 0;
        Rs[1] = 0;
        step();
        n_tests++;
        if (S[0] !== 32'h0 || S[1] !== 32'h0) begin
            n_fail++; $display("FAIL r0_write got %h %h want 0", S[0], S[1]);
        end
        idle();
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        do_reset();
        want = BYP ? 32'h12345678 : 32'h0;
        WB = 1; Rd = 7; reg_s = 32'h12345678;
        Rs[1] = 7;
        step();
        n_tests++;
        if (S[1] !== want) begin
            n_fail++; $display("FAIL same_cycle_read got %h want %h", S[1], want);
        end
        idle();
        Rs[1] = 7;
        step();
        n_tests++;
        if (S[1] !== 32'h12345678) begin
            n_fail++; $display("FAIL after_write_read got %h want 12345678", S[1]);
        end
        idle();
    endtask

    task automatic test_reserve_limit();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            Reserve = 1; Rr = 3;
            #1;
            n_tests++;
            if (reserve_ok !== 1'b1) begin
                n_fail++; $display("FAIL reserve_%0d got ok=%b want 1", k, reserve_ok);
            end
            step();
        end
        idle();
        Rs[0] = 3;
        Reserve = 1; Rr = 3;
        #1;
        n_tests++;
        if (Busy[0] !== 1'b1 || reserve_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL reserve_full got busy=%b ok=%b want 1 0", Busy[0], reserve_ok);
        end
        step();
        WB = 1; Rd = 3; reg_s = 32'hA5A5A5A5;
        #1;
        n_tests++;
        if (reserve_ok !== 1'b1) begin
            n_fail++; $display("FAIL reserve_with_wb got ok=%b want 1", reserve_ok);
        end
        step();
        idle();
        Reserve = 1; Rr = 3;
        #1;
        n_tests++;
        if (reserve_ok !== 1'b0) begin
            n_fail++; $display("FAIL reserve_cnt_held got ok=%b want 0", reserve_ok);
        end
        idle();
    endtask

    task automatic test_underflow();
        do_reset();
        WB = 1; Rd = 9; reg_s = 32'hCAFEF00D;
        step();
        idle();
        n_tests++;
        if (sb_err !== 1'b1) begin
            n_fail++; $display("FAIL underflow_err got %b want 1", sb_err);
        end
        Rs[0] = 9;
        step();
        step();
        n_tests++;
        if (sb_err !== 1'b1 || S[0] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL underflow_hold got err=%b S=%h want 1 cafef00d", sb_err, S[0]);
        end
        do_reset();
        n_tests++;
        if (sb_err !== 1'b0) begin
            n_fail++; $display("FAIL underflow_clear got %b want 0", sb_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        WB = 1; Rd = 4; reg_s = 32'h44444444;
        step();
        idle();
        Reserve = 1; Rr = 3;
        step();
        step();
        reset = 1;
        Reserve = 1; Rr = 3;
        WB = 1; Rd = 4; reg_s = 32'h55555555;
        Rs[0] = 4;
        step();
        idle();
        Rs[0] = 3;
        Rs[1] = 4;
        Rr = 3;
        #1;
        n_tests++;
        if (Busy !== 2'b00 || reserve_ok !== 1'b1 || S !== '0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%b ok=%b S=%h err=%b want 00 1 0 0",
                     Busy, reserve_ok, S, sb_err);
        end
        step();
        n_tests++;
        if (S[1] !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_wb got %h want 0", S[1]);
        end
        idle();
    endtask

    task automatic test_random();
        bit eb0;
        bit eb1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(60) == 0);
            WB      = $urandom_range(2) != 0;
            Rd      = 5'($urandom_range(7));
            reg_s   = $urandom;
            Rs[0]   = 5'($urandom_range(7));
            Rs[1]   = 5'($urandom_range(7));
            Reserve = $urandom_range(1) != 0;
            Rr      = 5'($urandom_range(7));
            #1;
            eb0 = exp_busy(0);
            eb1 = exp_busy(1);
            n_tests++;
            if (reserve_ok !== exp_ok() || Busy[0] !== eb0 || Busy[1] !== eb1) begin
                n_fail++;
                $display("FAIL rand_comb c=%0d got ok=%b busy=%b want ok=%b busy=%b%b",
                         c, reserve_ok, Busy, exp_ok(), eb1, eb0);
            end
            step();
            n_tests++;
            if (S[0] !== m_S[0] || S[1] !== m_S[1] || sb_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_seq c=%0d got S=%h %h err=%b want %h %h %b",
                         c, S[0], S[1], sb_err, m_S[0], m_S[1], m_err);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_write_read();
        test_bypass();
        test_reserve_limit();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
